// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Purpose : Shared types for the side-scroller game logic: the world
//           coordinate type, screen size, per-enemy state record and the
//           enemy-bank sequencer states.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package game_pkg;

    typedef logic [10:0] coord_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Enemy position is kept as a patrol offset from its fixed spawn x.
    typedef struct packed {
        coord_t offset;
        logic   dir;     // 1 = moving right
        logic   alive;
    } enemy_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        UPDATE  = 2'd1,
        COLLIDE = 2'd2
    } enemy_bank_state_e;

endpackage
`default_nettype wire

// File: rtl/aabb_overlap.sv
`default_nettype none
// ============================================================================
// Module  : aabb_overlap
// Purpose : Combinational strict axis-aligned box overlap test. Box A sits
//           at (i_ax,i_ay) with size A_W x A_H, box B at (i_bx,i_by) with
//           size B_W x B_H. A 1x1 box A turns this into a point-in-box test.
// Ports   : i_ax, i_ay, i_bx, i_by  12-bit box corners (top-left)
//           o_overlap               1 when the boxes share any pixel
// Rev     : 1.0  initial release
// ============================================================================
module aabb_overlap #(
    parameter int A_W = 32,
    parameter int A_H = 32,
    parameter int B_W = 32,
    parameter int B_H = 32
) (
    input  logic [11:0] i_ax,
    input  logic [11:0] i_ay,
    input  logic [11:0] i_bx,
    input  logic [11:0] i_by,
    output logic        o_overlap
);

    assign o_overlap = (i_ax < (i_bx + 12'(B_W))) &&
                       (i_bx < (i_ax + 12'(A_W))) &&
                       (i_ay < (i_by + 12'(B_H))) &&
                       (i_by < (i_ay + 12'(A_H)));

endmodule
`default_nettype wire

// File: rtl/enemy_bank.sv
`default_nettype none
// ============================================================================
// Module  : enemy_bank
// Purpose : Manages N_ENEMY patrolling enemies in world coordinates. On each
//           frame tick the sequencer walks every live enemy once to advance
//           its patrol, then once more to test it against the character box
//           (latching a sticky dead flag). A registered per-pixel path tells
//           the colour mapper whether the current pixel lies on an enemy.
// Ports   : Clk, Reset (sync, active-high), frame_clk (VGA_VS)
//           DrawX, DrawY, progress        -> pixel path inputs
//           characterX/Y, char_falling    -> collision inputs
//           is_enemy, hit_index, enemy_dir -> pixel path outputs (1 cycle)
//           dead, stomp_count             -> game status
// Config  : ENEMY_BANK_STOMP_EN - landing on an enemy from above removes it
//           instead of killing the character.
// Rev     : 1.0  initial release
// ============================================================================
module enemy_bank
    import game_pkg::*;
#(
    parameter int N_ENEMY    = 4,
    parameter int ENEMY_W    = 32,
    parameter int ENEMY_H    = 32,
    parameter int CHAR_W     = 32,
    parameter int CHAR_H     = 32,
    parameter int GROUND_Y   = 400,
    parameter int BASE_X     = 300,
    parameter int SPACING    = 200,
    parameter int PATROL     = 128,
    parameter int SPEED      = 1,
    parameter int STOMP_BAND = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [10:0] progress,
    input  logic [10:0] characterX,
    input  logic [10:0] characterY,
    input  logic        char_falling,
    output logic        is_enemy,
    output logic [5:0]  hit_index,
    output logic        enemy_dir,
    output logic        dead,
    output logic [7:0]  stomp_count
);

    localparam logic [11:0] c_EY   = 12'(GROUND_Y - ENEMY_H);
    localparam logic [5:0]  c_LAST = 6'(N_ENEMY - 1);

    enemy_bank_state_e r_state, w_state_nxt;
    logic [5:0]        r_idx, w_idx_nxt;
    logic              r_fclk_q;
    logic              w_tick;

    enemy_t             r_enemy [N_ENEMY];
    logic [11:0]        w_ex    [N_ENEMY];
    logic [N_ENEMY-1:0] w_pix_ov;

    logic [11:0] w_wx, w_wy, w_cx, w_cy;
    enemy_t      w_sel;
    logic [11:0] w_sel_ex;
    logic        w_col_ov, w_stomp;
    logic [11:0] w_up;
    logic [10:0] w_nxt_off;
    logic        w_nxt_dir;

    logic        w_pix_hit, w_pix_dir;
    logic [5:0]  w_pix_idx;
    logic        r_is_enemy, r_enemy_dir, r_dead;
    logic [5:0]  r_hit_index;

    assign w_tick = frame_clk & ~r_fclk_q;
    assign w_wx   = {1'b0, {1'b0, DrawX} + progress};
    assign w_wy   = {2'b00, DrawY};
    assign w_cx   = {1'b0, characterX};
    assign w_cy   = {1'b0, characterY};

    // Per-enemy world x and pixel hit test.
    generate
        for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_enemy
            assign w_ex[gi] = 12'(BASE_X + gi * SPACING) + {1'b0, r_enemy[gi].offset};

            aabb_overlap #(
                .A_W(1), .A_H(1), .B_W(ENEMY_W), .B_H(ENEMY_H)
            ) u_pix (
                .i_ax(w_wx), .i_ay(w_wy), .i_bx(w_ex[gi]), .i_by(c_EY),
                .o_overlap(w_pix_ov[gi])
            );
        end
    endgenerate

    // Enemy currently addressed by the sequencer.
    always_comb begin
        w_sel    = r_enemy[0];
        w_sel_ex = w_ex[0];
        for (int i = 1; i < N_ENEMY; i++) begin
            if (r_idx == 6'(i)) begin
                w_sel    = r_enemy[i];
                w_sel_ex = w_ex[i];
            end
        end
    end

    aabb_overlap #(
        .A_W(CHAR_W), .A_H(CHAR_H), .B_W(ENEMY_W), .B_H(ENEMY_H)
    ) u_col (
        .i_ax(w_cx), .i_ay(w_cy), .i_bx(w_sel_ex), .i_by(c_EY),
        .o_overlap(w_col_ov)
    );

    // Patrol step; both ends clamp exactly onto 0 / PATROL and turn around.
    always_comb begin
        w_up      = {1'b0, w_sel.offset} + 12'(SPEED);
        w_nxt_off = w_sel.offset;
        w_nxt_dir = w_sel.dir;
        if (w_sel.dir) begin
            if (w_up >= 12'(PATROL)) begin
                w_nxt_off = 11'(PATROL);
                w_nxt_dir = 1'b0;
            end else begin
                w_nxt_off = w_up[10:0];
            end
        end else begin
            if ({1'b0, w_sel.offset} <= 12'(SPEED)) begin
                w_nxt_off = '0;
                w_nxt_dir = 1'b1;
            end else begin
                w_nxt_off = w_sel.offset - 11'(SPEED);
            end
        end
    end

    // Sequencer: one enemy per cycle, N cycles of UPDATE then N of COLLIDE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_fclk_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_fclk_q <= frame_clk;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: begin
                if (w_tick && !r_dead) begin
                    w_state_nxt = UPDATE;
                    w_idx_nxt   = '0;
                end
            end
            UPDATE: begin
                w_idx_nxt = (r_idx == c_LAST) ? 6'd0 : r_idx + 6'd1;
                if (r_idx == c_LAST) w_state_nxt = COLLIDE;
            end
            COLLIDE: begin
                w_idx_nxt = (r_idx == c_LAST) ? 6'd0 : r_idx + 6'd1;
                if (r_idx == c_LAST) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Enemy state and the sticky dead flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                r_enemy[i].offset <= '0;
                r_enemy[i].dir    <= 1'b1;
                r_enemy[i].alive  <= 1'b1;
            end
            r_dead <= 1'b0;
        end else begin
            for (int i = 0; i < N_ENEMY; i++) begin
                if (r_idx == 6'(i) && r_enemy[i].alive) begin
                    if (r_state == UPDATE) begin
                        r_enemy[i].offset <= w_nxt_off;
                        r_enemy[i].dir    <= w_nxt_dir;
                    end else if (r_state == COLLIDE && w_col_ov && w_stomp) begin
                        r_enemy[i].alive <= 1'b0;
                    end
                end
            end
            if (r_state == COLLIDE && w_sel.alive && w_col_ov && !w_stomp) begin
                r_dead <= 1'b1;
            end
        end
    end

`ifdef ENEMY_BANK_STOMP_EN
    logic [7:0] r_stomp;

    // Stomp: falling, and the character's feet are no deeper than
    // STOMP_BAND into the enemy's top edge.
    assign w_stomp = char_falling &&
                     ((w_cy + 12'(CHAR_H)) <= (c_EY + 12'(STOMP_BAND)));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stomp <= '0;
        end else if (r_state == COLLIDE && w_sel.alive && w_col_ov && w_stomp &&
                     r_stomp != 8'hFF) begin
            r_stomp <= r_stomp + 8'd1;
        end
    end

    assign stomp_count = r_stomp;
`else
    logic w_unused_stomp;

    assign w_unused_stomp = char_falling | (STOMP_BAND < 0);
    assign w_stomp        = 1'b0;
    assign stomp_count    = 8'd0;
`endif

    // Pixel path: lowest-index live enemy wins.
    always_comb begin
        w_pix_hit = 1'b0;
        w_pix_idx = '0;
        w_pix_dir = 1'b0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            if (w_pix_ov[i] && r_enemy[i].alive) begin
                w_pix_hit = 1'b1;
                w_pix_idx = 6'(i);
                w_pix_dir = r_enemy[i].dir;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_is_enemy  <= 1'b0;
            r_hit_index <= '0;
            r_enemy_dir <= 1'b0;
        end else begin
            r_is_enemy  <= w_pix_hit;
            r_hit_index <= w_pix_idx;
            r_enemy_dir <= w_pix_dir;
        end
    end

    assign is_enemy  = r_is_enemy;
    assign hit_index = r_hit_index;
    assign enemy_dir = r_enemy_dir;
    assign dead      = r_dead;

endmodule
`default_nettype wire

// File: tb/tb_enemy_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_enemy_bank
// Purpose : Self-checking bench for enemy_bank (N_ENEMY=4, defaults).
//           Stimulus pushes expected pixel/status values into a queue; a
//           monitor pops and compares one cycle later when the pixel path
//           output for that request is presented.
// Rev     : 1.0  initial release
// ============================================================================
module tb_enemy_bank;

    localparam int c_N = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic [9:0]  DrawX, DrawY;
    logic [10:0] progress, characterX, characterY;
    logic        char_falling;
    logic        is_enemy, enemy_dir, dead;
    logic [5:0]  hit_index;
    logic [7:0]  stomp_count;

    always #5 Clk = ~Clk;

    enemy_bank #(.N_ENEMY(c_N)) dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
        .DrawX(DrawX), .DrawY(DrawY), .progress(progress),
        .characterX(characterX), .characterY(characterY),
        .char_falling(char_falling),
        .is_enemy(is_enemy), .hit_index(hit_index), .enemy_dir(enemy_dir),
        .dead(dead), .stomp_count(stomp_count)
    );

    typedef struct {
        string      name;
        logic       is_e;
        logic [5:0] idx;
        logic       dir;
        logic       dd;
        logic [7:0] sc;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic r_req   = 1'b0;
    logic r_req_q = 1'b0;

    always @(posedge Clk) r_req_q <= r_req;

    // Monitor: output for a request is valid on the negedge after the
    // posedge that captured it.
    always @(negedge Clk) begin : p_mon
        exp_t e;
        if (r_req_q === 1'b1) begin
            n_cmp++;
            if (q_exp.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got is_enemy=%0b with no expectation queued", is_enemy);
            end else begin
                e = q_exp.pop_front();
                if (is_enemy !== e.is_e || hit_index !== e.idx || enemy_dir !== e.dir ||
                    dead !== e.dd || stomp_count !== e.sc) begin
                    n_err++;
                    $display("FAIL %s: got is_enemy=%0b hit_index=%0d enemy_dir=%0b dead=%0b stomp=%0d, expected %0b %0d %0b %0b %0d",
                             e.name, is_enemy, hit_index, enemy_dir, dead, stomp_count,
                             e.is_e, e.idx, e.dir, e.dd, e.sc);
                end
            end
        end
    end

    // All tasks start and end just after a negedge.
    task automatic chk(input string nm, input int prog, input int dx, input int dy,
                       input int ei, input int ix, input int di, input int dd, input int sc);
        exp_t e;
        progress = 11'(prog);
        DrawX    = 10'(dx);
        DrawY    = 10'(dy);
        e.name = nm;
        e.is_e = 1'(ei);
        e.idx  = 6'(ix);
        e.dir  = 1'(di);
        e.dd   = 1'(dd);
        e.sc   = 8'(sc);
        q_exp.push_back(e);
        r_req = 1'b1;
        @(negedge Clk);
        r_req = 1'b0;
    endtask

    // Rising frame_clk, then wait out the 2N-cycle busy window.
    task automatic tick();
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2 * c_N + 1) @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish first");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset        = 1'b1;
        frame_clk    = 1'b0;
        DrawX        = '0;
        DrawY        = '0;
        progress     = '0;
        characterX   = '0;
        characterY   = '0;
        char_falling = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset state: pixel points at enemy 0 but reset forces outputs low.
        chk("reset_state", 0, 300, 368, 0, 0, 0, 0, 0);
        Reset = 1'b0;

        // Spawn positions: enemy 0 at x=300..331, y=368..399.
        chk("spawn0_hit",     0, 300, 368, 1, 0, 1, 0, 0);
        chk("spawn0_left",    0, 299, 368, 0, 0, 0, 0, 0);
        chk("spawn0_right_in",0, 331, 368, 1, 0, 1, 0, 0);
        chk("spawn0_right_out",0,332, 368, 0, 0, 0, 0, 0);
        chk("spawn0_top_out", 0, 300, 367, 0, 0, 0, 0, 0);
        chk("spawn0_bot_in",  0, 300, 399, 1, 0, 1, 0, 0);
        chk("spawn0_bot_out", 0, 300, 400, 0, 0, 0, 0, 0);
        chk("scroll_enemy1",  200, 300, 368, 1, 1, 1, 0, 0);
        chk("scroll_enemy0",  200, 100, 368, 1, 0, 1, 0, 0);
        chk("scroll_enemy3",  600, 300, 368, 1, 3, 1, 0, 0);

        // Patrol.
        tick();
        chk("tick1_x301", 0, 301, 368, 1, 0, 1, 0, 0);
        chk("tick1_x300", 0, 300, 368, 0, 0, 0, 0, 0);
        repeat (127) tick();
        chk("tick128_x428", 0, 428, 368, 1, 0, 0, 0, 0);
        chk("tick128_x427", 0, 427, 368, 0, 0, 0, 0, 0);
        tick();
        chk("tick129_x427", 0, 427, 368, 1, 0, 0, 0, 0);
        chk("tick129_x459", 0, 459, 368, 0, 0, 0, 0, 0);

        // Reset in the middle of UPDATE (enemy 0 already stepped).
        frame_clk = 1'b1;
        @(negedge Clk);
        frame_clk = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("rst_mid_x300",  0, 300, 368, 1, 0, 1, 0, 0);
        chk("rst_mid_x299",  0, 299, 368, 0, 0, 0, 0, 0);
        tick();
        chk("rst_mid_resume", 0, 300, 368, 0, 0, 0, 0, 0);
        chk("rst_mid_x301",  0, 301, 368, 1, 0, 1, 0, 0);

        // Falling onto enemy 0 from above.
        do_reset();
        characterX   = 11'd310;
        characterY   = 11'd340;
        char_falling = 1'b1;
        tick();
`ifdef ENEMY_BANK_STOMP_EN
        chk("stomp_removed", 0, 305, 368, 0, 0, 0, 0, 1);
        chk("stomp_enemy1",  200, 305, 368, 1, 1, 1, 0, 1);
`else
        chk("fall_is_death", 0, 305, 368, 1, 0, 1, 1, 0);
        chk("fall_enemy1",   200, 305, 368, 1, 1, 1, 1, 0);
`endif

        // Side collision: death, sticky, enemies freeze.
        do_reset();
        characterX   = 11'd310;
        characterY   = 11'd368;
        char_falling = 1'b0;
        tick();
        chk("dead_set", 0, 301, 368, 1, 0, 1, 1, 0);
        characterX = 11'd0;
        characterY = 11'd0;
        chk("dead_sticky", 0, 333, 368, 0, 0, 0, 1, 0);
        tick();
        tick();
        chk("frozen_x301", 0, 301, 368, 1, 0, 1, 1, 0);
        chk("frozen_x333", 0, 333, 368, 0, 0, 0, 1, 0);
        chk("frozen_x332", 0, 332, 368, 1, 0, 1, 1, 0);

        repeat (3) @(negedge Clk);
        if (q_exp.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue_drain: got %0d pending expectations, expected 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
